rf_writeback_ctrl: RTL and testbench

//   Write-side controller for the integer register file. Collects writeback

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_wb_fifo.sv | 51 +++++
 rtl/rf_writeback_ctrl.sv | 124 ++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and the writeback request payload for the register-file write side.
package rf_pkg;

  localparam int unsigned D_WIDTH       = 32;
  localparam int unsigned ADDRESS_WIDTH = 5;
  localparam int unsigned FIFO_DEPTH    = 4;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [D_WIDTH-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small FIFO buffering long-latency writeback requests until the write port is free.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head_c,
  output logic    full_c,
  output logic    empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  // Full refuses a push even when a pop happens in the same cycle.
  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;
  assign head_c  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-side controller: ALU/long-latency arbitration, registered
// write port, and a per-register busy scoreboard for decode hazard stalls.
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned D_WIDTH       = rf_pkg::D_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int unsigned FIFO_DEPTH    = rf_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [D_WIDTH-1:0]       alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [D_WIDTH-1:0]       mem_data,
  input  logic                     issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic [ADDRESS_WIDTH-1:0] dec_rs1,
  input  logic [ADDRESS_WIDTH-1:0] dec_rs2,
  input  logic [ADDRESS_WIDTH-1:0] dec_rd,
  output logic                     stall,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] a3,
  output logic [D_WIDTH-1:0]       din
);

  localparam int unsigned NUM_REGS = 2 ** ADDRESS_WIDTH;

  wb_req_t                  push_req;
  wb_req_t                  head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     ready_q;
  logic                     wr_en_d;
  logic [ADDRESS_WIDTH-1:0] a3_d;
  logic [D_WIDTH-1:0]       din_d;
  logic [ADDRESS_WIDTH-1:0] head_rd;
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      set_vec;
  logic [NUM_REGS-1:0]      clr_vec;

  // Holds mem_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign mem_ready = ready_q & ~fifo_full;
  assign push      = mem_valid & mem_ready;
  assign pop       = ~alu_valid & ~fifo_empty;
  assign head_rd   = ADDRESS_WIDTH'(head.rd);

  always_comb begin
    push_req      = '0;
    push_req.rd   = mem_rd;
    push_req.data = mem_data;
  end

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head_c    (head),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  // ALU has strict priority; x0 requests are consumed without a write.
  always_comb begin
    wr_en_d = 1'b0;
    a3_d    = a3;
    din_d   = din;
    if (alu_valid) begin
      if (alu_rd != '0) begin
        wr_en_d = 1'b1;
        a3_d    = alu_rd;
        din_d   = alu_data;
      end
    end else if (!fifo_empty) begin
      if (head_rd != '0) begin
        wr_en_d = 1'b1;
        a3_d    = head_rd;
        din_d   = D_WIDTH'(head.data);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en <= 1'b0;
      a3    <= '0;
      din   <= '0;
    end else begin
      wr_en <= wr_en_d;
      a3    <= a3_d;
      din   <= din_d;
    end
  end

  // Issue sets, FIFO pop clears; set wins when both hit the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && (issue_rd != '0)) set_vec[issue_rd] = 1'b1;
    if (pop)                             clr_vec[head_rd]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~clr_vec) | set_vec;
  end

  assign stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl: expected writes are queued as stimulus is
// driven and matched against each register-file write the controller issues.
module tb_rf_writeback_ctrl;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        stall;
  logic        wr_en;
  logic [4:0]  a3;
  logic [31:0] din;

  wb_req_t exp_q[$];
  int      checks   = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .stall       (stall),
    .wr_en       (wr_en),
    .a3          (a3),
    .din         (din)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wb_req_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one clock and score any write that appeared on the port.
  task automatic tick();
    wb_req_t e;
    @(posedge clk);
    #1;
    if (wr_en !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(wr_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_a3", 32'(a3), 32'(e.rd));
        chk("wb_din", din, e.data);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    mem_valid   = 1'b0;
    mem_rd      = '0;
    mem_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_rd      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_a3", 32'(a3), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("post_rst_wr_en", 32'(wr_en), 32'd0);

    // Single ALU write, then idle hold of a3/din
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    chk("alu_wr_en", 32'(wr_en), 32'd1);
    alu_valid = 1'b0;
    tick();
    chk("alu_idle_wr_en", 32'(wr_en), 32'd0);
    chk("alu_idle_a3_hold", 32'(a3), 32'd5);
    chk("alu_idle_din_hold", din, 32'hDEADBEEF);

    // Scoreboard set on issue, cleared by the long-latency writeback
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    dec_rs1     = 5'd7;
    #1;
    chk("busy7_stall", 32'(stall), 32'd1);
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'h1234;
    expect_wr(5'd7, 32'h1234);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("busy7_stall_queued", 32'(stall), 32'd1);
    tick();
    chk("mem7_wr_en", 32'(wr_en), 32'd1);
    chk("busy7_cleared", 32'(stall), 32'd0);
    dec_rs1 = '0;

    // Fill the FIFO behind a continuous ALU stream
    alu_valid = 1'b1;
    alu_rd    = 5'd10;
    for (int i = 1; i <= 4; i++) begin
      alu_data  = 32'hA000_0000 + 32'(i);
      expect_wr(5'd10, 32'hA000_0000 + 32'(i));
      mem_valid = 1'b1;
      mem_rd    = 5'(i);
      mem_data  = 32'h100 + 32'(i);
      tick();
      chk("fill_mem_ready", 32'(mem_ready), 32'(i < 4));
    end

    // Drain; a push offered while full is refused despite the same-cycle pop
    alu_valid = 1'b0;
    mem_rd    = 5'd5;
    mem_data  = 32'h105;
    for (int i = 1; i <= 4; i++) expect_wr(5'(i), 32'h100 + 32'(i));
    tick();
    chk("drain1_wr_en", 32'(wr_en), 32'd1);
    chk("drain1_mem_ready", 32'(mem_ready), 32'd1);
    mem_rd   = 5'd6;
    mem_data = 32'h106;
    expect_wr(5'd6, 32'h106);
    tick();
    chk("push_pop_mem_ready", 32'(mem_ready), 32'd1);
    mem_valid = 1'b0;
    repeat (3) tick();
    tick();
    chk("drained_wr_en", 32'(wr_en), 32'd0);
    chk("drained_queue", 32'(exp_q.size()), 32'd0);

    // x0 handling on ALU, issue and FIFO paths
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hFFFFFFFF;
    tick();
    chk("x0_alu_wr_en", 32'(wr_en), 32'd0);
    alu_valid   = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    mem_valid   = 1'b1;
    mem_rd      = 5'd0;
    mem_data    = 32'hFFFF;
    tick();
    issue_valid = 1'b0;
    mem_valid   = 1'b0;
    dec_rs1     = 5'd0;
    #1;
    chk("x0_issue_stall", 32'(stall), 32'd0);
    tick();
    chk("x0_mem_wr_en", 32'(wr_en), 32'd0);
    chk("x0_a3_hold", 32'(a3), 32'd6);
    tick();
    chk("x0_mem_ready", 32'(mem_ready), 32'd1);

    // Reset in the middle of a drain discards pending writes and busy bits
    issue_valid = 1'b1;
    for (int r = 20; r <= 22; r++) begin
      issue_rd = 5'(r);
      tick();
    end
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd11;
    for (int k = 0; k < 3; k++) begin
      alu_data  = 32'hB000_0000 + 32'(k);
      expect_wr(5'd11, 32'hB000_0000 + 32'(k));
      mem_valid = 1'b1;
      mem_rd    = 5'(20 + k);
      mem_data  = 32'h200 + 32'(k);
      tick();
    end
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    expect_wr(5'd20, 32'h200);
    tick();
    chk("mid_drain_wr_en", 32'(wr_en), 32'd1);
    dec_rs1 = 5'd21;
    dec_rd  = 5'd22;
    #1;
    chk("mid_drain_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr_en", 32'(wr_en), 32'd0);
    chk("async_rst_a3", 32'(a3), 32'd0);
    chk("async_rst_din", din, 32'd0);
    chk("async_rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_no_write", 32'(wr_en), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
